// File: rtl/bus_cycle_ctrl.sv
// 68k bus-cycle sequencer: DTACK wait states, external ack pass-through,
// watchdog and decode-conflict BERR, saturating BERR event counter.
module bus_cycle_ctrl #(
  parameter int ROM_WAIT  = 2,
  parameter int RAM_WAIT  = 0,
  parameter int IO_WAIT   = 3,
  parameter int WD_CYCLES = 128
) (
  input  logic       CLK,
  input  logic       HWRST,
  input  logic       ASn,
  input  logic       ROMSEL,
  input  logic       RAMSEL,
  input  logic       IOSEL,
  input  logic       EXPSEL,
  input  logic       IACK,
  input  logic       EXT_DTACKn,
  output logic       DTACK_OE,
  output logic       BERR_OE,
  output logic       BUSY,
  output logic [7:0] ERR_COUNT
);

  localparam int WD_W = $clog2(WD_CYCLES);
  localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
  localparam logic [3:0] IO_W  = 4'(IO_WAIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EXTWAIT,
    S_ACK,
    S_BERR,
    S_DONE
  } state_t;

  state_t          state, nxt;
  logic [1:0]      as_s, ack_s, prime;
  logic [3:0]      wcnt, wcnt_nxt;
  logic [WD_W-1:0] wd, wd_nxt;
  logic            as_act, ext_ack;
  logic [2:0]      nsel;
  logic            int_hit;
  logic [3:0]      int_wait;

  assign as_act  = ~as_s[1];
  assign ext_ack = ~ack_s[1];
  assign BUSY    = (state != S_IDLE);

  assign nsel = 3'(ROMSEL) + 3'(RAMSEL) + 3'(IOSEL)
              + 3'(EXPSEL) + 3'(IACK);
  assign int_hit  = ROMSEL | RAMSEL | IOSEL;
  assign int_wait = ({4{ROMSEL}} & ROM_W)
                  | ({4{RAMSEL}} & RAM_W)
                  | ({4{IOSEL}}  & IO_W);

  always_ff @(posedge CLK) begin
    if (HWRST) begin
      as_s      <= 2'b11;
      ack_s     <= 2'b11;
      prime     <= 2'b00;
      state     <= S_DONE;
      wcnt      <= '0;
      wd        <= '0;
      DTACK_OE  <= 1'b0;
      BERR_OE   <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      as_s     <= {as_s[0], ASn};
      ack_s    <= {ack_s[0], EXT_DTACKn};
      prime    <= {prime[0], 1'b1};
      state    <= nxt;
      wcnt     <= wcnt_nxt;
      wd       <= wd_nxt;
      DTACK_OE <= (nxt == S_ACK);
      BERR_OE  <= (nxt == S_BERR);
      if (nxt == S_BERR && state != S_BERR && ERR_COUNT != 8'hFF)
        ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

  // prime blocks DONE exit until the synchronizer holds real ASn samples
  always_comb begin
    nxt      = state;
    wcnt_nxt = wcnt;
    wd_nxt   = wd;
    case (state)
      S_IDLE: begin
        if (as_act) begin
          if (nsel > 3'd1) begin
            nxt = S_BERR;
          end else if (int_hit) begin
            if (int_wait == 4'd0) begin
              nxt = S_ACK;
            end else begin
              wcnt_nxt = int_wait;
              nxt      = S_WAIT;
            end
          end else begin
            wd_nxt = '0;
            nxt    = S_EXTWAIT;
          end
        end
      end
      S_WAIT: begin
        if (!as_act)
          nxt = S_IDLE;
        else if (wcnt == 4'd1)
          nxt = S_ACK;
        else
          wcnt_nxt = wcnt - 4'd1;
      end
      S_EXTWAIT: begin
        if (!as_act)
          nxt = S_IDLE;
        else if (ext_ack)
          nxt = S_DONE;
        else if (wd == WD_LAST)
          nxt = S_BERR;
        else
          wd_nxt = wd + 1'b1;
      end
      S_ACK, S_BERR: begin
        if (!as_act)
          nxt = S_IDLE;
      end
      S_DONE: begin
        if (!as_act && prime[1])
          nxt = S_IDLE;
      end
      default: nxt = S_DONE;
    endcase
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: table of single bus cycles plus
// reset-in-ACK, aborted cycle and counter saturation sequences.
module tb_bus_cycle_ctrl;

  logic       CLK = 1'b0;
  logic       HWRST, ASn, ROMSEL, RAMSEL, IOSEL, EXPSEL, IACK, EXT_DTACKn;
  logic       DTACK_OE, BERR_OE, BUSY;
  logic [7:0] ERR_COUNT;

  int nchk = 0;
  int nerr = 0;
  int model_cnt = 0;

  bus_cycle_ctrl #(
    .ROM_WAIT(2), .RAM_WAIT(0), .IO_WAIT(3), .WD_CYCLES(128)
  ) dut (
    .CLK(CLK), .HWRST(HWRST), .ASn(ASn),
    .ROMSEL(ROMSEL), .RAMSEL(RAMSEL), .IOSEL(IOSEL),
    .EXPSEL(EXPSEL), .IACK(IACK), .EXT_DTACKn(EXT_DTACKn),
    .DTACK_OE(DTACK_OE), .BERR_OE(BERR_OE), .BUSY(BUSY),
    .ERR_COUNT(ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  typedef struct {
    logic [4:0] sel;
    int ext_at;
    int hold;
    int kind;
    int lat;
    string name;
  } vec_t;

  function automatic vec_t mk(logic [4:0] s, int e, int h, int k,
                              int l, string n);
    vec_t v;
    v.sel = s; v.ext_at = e; v.hold = h;
    v.kind = k; v.lat = l; v.name = n;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_sel(logic [4:0] s);
    {ROMSEL, RAMSEL, IOSEL, EXPSEL, IACK} = s;
  endtask

  // kind: 0 no ack driven, 1 DTACK, 2 BERR; lat in edges after edge k
  task automatic run_cycle(vec_t v);
    int got_k, got_l, both;
    got_k = 0; got_l = -1; both = 0;
    set_sel(v.sel);
    ASn = 1'b0;
    for (int t = 0; t < v.hold; t++) begin
      tick();
      if (t == v.ext_at) EXT_DTACKn = 1'b0;
      if (DTACK_OE && BERR_OE) both = 1;
      if (got_k == 0) begin
        if (DTACK_OE) begin got_k = 1; got_l = t; end
        else if (BERR_OE) begin got_k = 2; got_l = t; end
      end
    end
    chk({v.name, "_kind"}, got_k, v.kind);
    if (v.kind != 0) chk({v.name, "_lat"}, got_l, v.lat);
    chk({v.name, "_both"}, both, 0);
    if (v.kind == 2 && model_cnt < 255) model_cnt++;
    ASn = 1'b1;
    EXT_DTACKn = 1'b1;
    set_sel(5'b0);
    tick(); tick(); tick();
    chk({v.name, "_rel_dtack"}, int'(DTACK_OE), 0);
    chk({v.name, "_rel_berr"}, int'(BERR_OE), 0);
    chk({v.name, "_rel_busy"}, int'(BUSY), 0);
    chk({v.name, "_cnt"}, int'(ERR_COUNT), model_cnt);
  endtask

  vec_t vt[11];
  int   seen;

  initial begin
    vt[0]  = mk(5'b01000, -1,  10, 1,   2, "ram");
    vt[1]  = mk(5'b10000, -1,  10, 1,   4, "rom");
    vt[2]  = mk(5'b00100, -1,  10, 1,   5, "io_b2b");
    vt[3]  = mk(5'b00010, 20, 200, 0,   0, "exp_ack20");
    vt[4]  = mk(5'b00000, -1, 140, 2, 130, "wd_timeout");
    vt[5]  = mk(5'b00000, 127, 140, 0,  0, "ack_on_to_edge");
    vt[6]  = mk(5'b00000, 128, 140, 2, 130, "ack_after_to");
    vt[7]  = mk(5'b00001,  5,  20, 0,   0, "iack_ext");
    vt[8]  = mk(5'b11000, -1,  10, 2,   2, "rom_ram_conf");
    vt[9]  = mk(5'b00110, -1,  10, 2,   2, "io_exp_conf");
    vt[10] = mk(5'b01001, -1,  10, 2,   2, "ram_iack_conf");

    HWRST = 1'b1; ASn = 1'b1; EXT_DTACKn = 1'b1;
    set_sel(5'b0);
    tick(); tick();
    chk("rst_dtack", int'(DTACK_OE), 0);
    chk("rst_berr", int'(BERR_OE), 0);
    chk("rst_busy", int'(BUSY), 1);
    chk("rst_cnt", int'(ERR_COUNT), 0);
    HWRST = 1'b0;
    tick(); tick(); tick(); tick();
    chk("post_rst_idle", int'(BUSY), 0);

    for (int i = 0; i < 11; i++) run_cycle(vt[i]);

    // reset while acknowledging, ASn held low throughout
    RAMSEL = 1'b1;
    ASn = 1'b0;
    tick(); tick(); tick();
    chk("rstack_pre", int'(DTACK_OE), 1);
    HWRST = 1'b1;
    tick();
    chk("rstack_dtack", int'(DTACK_OE), 0);
    chk("rstack_busy", int'(BUSY), 1);
    chk("rstack_cnt", int'(ERR_COUNT), 0);
    model_cnt = 0;
    HWRST = 1'b0;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (DTACK_OE || BERR_OE) seen = 1;
    end
    chk("rstack_no_reack", seen, 0);
    ASn = 1'b1;
    RAMSEL = 1'b0;
    tick(); tick(); tick();
    chk("rstack_idle", int'(BUSY), 0);
    run_cycle(mk(5'b01000, -1, 10, 1, 2, "ram_after_rst"));

    // ROM cycle aborted inside its wait states
    ROMSEL = 1'b1;
    ASn = 1'b0;
    tick(); tick();
    ASn = 1'b1;
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (DTACK_OE || BERR_OE) seen = 1;
    end
    ROMSEL = 1'b0;
    chk("abort_no_ack", seen, 0);
    chk("abort_idle", int'(BUSY), 0);
    chk("abort_cnt", int'(ERR_COUNT), model_cnt);

    for (int i = 0; i < 300; i++)
      run_cycle(mk(5'b11000, -1, 6, 2, 2, "sat"));
    chk("sat_final", int'(ERR_COUNT), 255);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

Bus-cycle sequencer for the 68k glue CPLD. It sits behind the address decoder and owns DTACK and BERR generation for every CPU bus cycle. It inserts per-region wait states for on-board ROM, RAM and IO. For expansion, IACK and undecoded cycles it passes through the external acknowledge, and it raises a bus error after a watchdog timeout or on a decode conflict.

## Interface
Parameters:
- ROM_WAIT, 2: wait states before DTACK for ROM cycles (0-15)
- RAM_WAIT, 0: wait states for RAM cycles (0-15)
- IO_WAIT, 3: wait states for IO cycles (0-15)
- WD_CYCLES, 128: clocks without acknowledge before BERR (2-65535)

Ports:
- CLK  in  1  CPU clock; all logic on rising edge
- HWRST  in  1  reset, synchronous, active-high
- ASn  in  1  CPU address strobe, asynchronous, active-low
- ROMSEL, RAMSEL, IOSEL  in  1 each  decoded region strobes, active-high, stable while ASn low
- EXPSEL  in  1  expansion region strobe, active-high
- IACK  in  1  interrupt-acknowledge cycle (FC=111), active-high
- EXT_DTACKn  in  1  acknowledge from expansion/DUART, asynchronous, active-low
- DTACK_OE  out  1  drive DTACKn low (top level tri-states)
- BERR_OE  out  1  drive BERRn low
- BUSY  out  1  state != IDLE
- ERR_COUNT  out  8  saturating count of BERR events

## Operation
- ASn and EXT_DTACKn each pass through a 2-flop synchronizer; as_act = synchronized ASn low, ext_ack = synchronized EXT_DTACKn low.
- Region strobes are sampled only in IDLE. They are trusted stable for the cycle.
- States: IDLE, WAIT, EXTWAIT, ACK, BERR, DONE.
- IDLE, as_act:
  - More than one of ROMSEL/RAMSEL/IOSEL/EXPSEL/IACK high -> BERR (decode conflict).
  - Exactly one of ROMSEL/RAMSEL/IOSEL with wait N: N=0 -> ACK; else load wcnt=N -> WAIT.
  - EXPSEL, IACK, or no strobe -> EXTWAIT with wd=0.
- WAIT: wcnt==1 -> ACK, else wcnt-1.
- EXTWAIT:
  - ext_ack -> DONE. The block never drives DTACK for external cycles.
  - Else wd==WD_CYCLES-1 -> BERR.
  - Else wd+1.
  - ext_ack wins over a simultaneous timeout.
- ACK: DTACK_OE=1 until !as_act -> IDLE.
- BERR: BERR_OE=1 until !as_act -> IDLE. ERR_COUNT increments by 1 on each entry, saturating at 255.
- DONE: wait for !as_act -> IDLE.
- !as_act in WAIT or EXTWAIT (aborted cycle) -> IDLE. No DTACK, no BERR, no count.
- DTACK_OE and BERR_OE are registered and decoded from state. They are never both high.
- Counter widths: wcnt 4 bits; wd is $clog2(WD_CYCLES) bits.

## Timing
- Reset: HWRST high at an edge puts the block in DONE. Reset values: DTACK_OE=0, BERR_OE=0, ERR_COUNT=0, BUSY=1, wcnt=0, wd=0, synchronizers=1 (inactive).
- Reset mid-cycle drops DTACK/BERR at that edge. After release, the block waits for ASn negation before accepting a new cycle, so it never acknowledges a half-seen cycle.
- Edge k is the first edge sampling ASn low. IDLE exits at edge k+2.
- Internal region with wait N: DTACK_OE high after edge k+2+N.
- Timeout: BERR_OE high after edge k+2+WD_CYCLES.
- External ack: EXT_DTACKn low sampled at edge j gives exit to DONE at edge j+2.
- Release: ASn high sampled at edge m; DTACK_OE/BERR_OE low and state IDLE after edge m+2.
- Back-to-back cycles: a new ASn low seen in IDLE starts immediately. There is no idle penalty beyond synchronizer latency.

## Test plan
- RAM cycle, RAM_WAIT=0: ASn low at edge 10 -> DTACK_OE=1 after edge 12. ASn high at edge 20 -> DTACK_OE=0 after edge 22. ERR_COUNT stays 0.
- ROM cycle, ROM_WAIT=2, then IO cycle, IO_WAIT=3, back-to-back -> DTACK_OE rises at k+4 and k+5 respectively. BUSY low between the cycles.
- EXPSEL cycle, EXT_DTACKn low after 20 clocks -> DTACK_OE never asserts, BERR_OE stays 0. State returns to IDLE 2 clocks after ASn high.
- No strobe, EXT_DTACKn held high, WD_CYCLES=128 -> BERR_OE=1 after edge k+130, ERR_COUNT=1. EXT_DTACKn arriving on the timeout edge -> DONE, no BERR.
- ROMSEL and RAMSEL both high -> BERR_OE=1 after edge k+2. Repeated 300 times -> ERR_COUNT=255.
- HWRST pulsed while in ACK with ASn held low -> DTACK_OE=0 at the reset edge. No new DTACK until ASn goes high and then low again. ERR_COUNT=0.
